// File: rtl/scan_pkg.sv
// Shared slot encoding for the 4-digit display scan: Gray select codes, anode
// patterns and the mux input mapping used by both the nibble mux and digit_scan_ctrl.
package scan_pkg;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b11,
    SEL_D3 = 2'b10
  } sel_e;

  // Mux input routed by each select code; identical encoding to sel_e by construction.
  typedef enum logic [1:0] {
    MUX_IN_A = 2'b00,
    MUX_IN_B = 2'b01,
    MUX_IN_C = 2'b11,
    MUX_IN_D = 2'b10
  } mux_in_e;

  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic sel_e next_sel(input sel_e s);
    sel_e n;
    case (s)
      SEL_D0:  n = SEL_D1;
      SEL_D1:  n = SEL_D2;
      SEL_D2:  n = SEL_D3;
      SEL_D3:  n = SEL_D0;
      default: n = SEL_D0;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] sel_to_an(input sel_e s);
    logic [3:0] a;
    case (s)
      SEL_D0:  a = 4'b1110;
      SEL_D1:  a = 4'b1101;
      SEL_D2:  a = 4'b1011;
      SEL_D3:  a = 4'b0111;
      default: a = AN_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Per-digit dwell counter: counts 0..CLK_DIV-1 while enabled, clears while disabled,
// and flags the edge on which it wraps.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count and wrap strobe; the strobe marks the edge that returns cnt to zero.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (!en) begin
      cnt_d = CNT_W'(0);
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_W'(0);
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display: Gray select, active-low anodes
// and frame tick. Define SCAN_GUARD_EN to blank anodes for GUARD_CYCLES per slot.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_s;
  logic             wrap_s;
  logic             guard_s;

  sel_e       sel_d, sel_q;
  logic [3:0] an_d, an_q;
  logic       frame_tick_d, frame_tick_q;

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cnt   (cnt_s),
    .wrap  (wrap_s)
  );

`ifdef SCAN_GUARD_EN
  logic [CNT_W-1:0] cnt_next_s;
  // The disabled case never reaches the guard test, so only wrap vs. increment matters.
  assign cnt_next_s = wrap_s ? CNT_W'(0) : (cnt_s + CNT_W'(1));
  assign guard_s    = (cnt_next_s < CNT_W'(GUARD_CYCLES));
`else
  logic unused_cnt_s;
  assign unused_cnt_s = ^cnt_s;
  assign guard_s      = 1'b0;
`endif

  // Slot advance, anode pattern and frame tick, all from next-state values.
  always_comb begin
    sel_d        = sel_q;
    an_d         = AN_OFF;
    frame_tick_d = 1'b0;
    if (en) begin
      if (wrap_s) begin
        sel_d        = next_sel(sel_q);
        frame_tick_d = (sel_q == SEL_D3);
      end else begin
        sel_d        = sel_q;
        frame_tick_d = 1'b0;
      end
      if (guard_s) begin
        an_d = AN_OFF;
      end else begin
        an_d = sel_to_an(sel_d);
      end
    end else begin
      sel_d        = sel_q;
      an_d         = AN_OFF;
      frame_tick_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= SEL_D0;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
